acc32_stage: RTL and testbench

ACC32_STAGE -- requirements
Module: acc32_stage

---
 rtl/acc32_pkg.sv | 18 +
 rtl/acc32_ctrl.sv | 82 ++++++++
 rtl/acc32_stage.sv | 64 ++++++
 tb/tb_acc32_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc32_pkg.sv
// Shared definitions for the acc32 accumulator slice: data width, FSM states
// and accumulator sizing. Saturation is selected in acc32_stage by ACC32_STAGE_SAT_EN.
package acc32_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Carry-out bit plus log2(beats) guard bits make the sum lossless.
    function automatic int acc_width(input int beats);
        return DATA_W + 1 + $clog2(beats);
    endfunction

endpackage

// File: rtl/acc32_ctrl.sv
// Sequencing for acc32_stage: tracks the beat count and IDLE/ACCUM/HOLD state,
// and tells the datapath when to load or add a beat.
module acc32_ctrl
    import acc32_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic load,
    output logic add
);

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             accept;

    // Handshake outputs are pure state decode so no input reaches them combinationally.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        load      = 1'b0;
        add       = 1'b0;
        if (clr) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        load      = 1'b1;
                        count_nxt = CNT_W'(1);
                        state_nxt = ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        add       = 1'b1;
                        count_nxt = count + CNT_W'(1);
                        if (count + CNT_W'(1) == LAST) begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/acc32_stage.sv
// Sums BEATS consecutive {carry, sum} adder results into one 32-bit result with overflow flag.
// Define ACC32_STAGE_SAT_EN to saturate out_sum on overflow instead of truncating.
module acc32_stage
    import acc32_pkg::*;
#(
    parameter int BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_s,
    input  logic              in_co,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf
);

    localparam int ACC_W = acc_width(BEATS);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] beat_ext;
    logic             load;
    logic             add;

    acc32_ctrl #(
        .BEATS(BEATS)
    ) u_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .load     (load),
        .add      (add)
    );

    assign beat_ext = {{(ACC_W - DATA_W - 1){1'b0}}, in_co, in_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load) begin
            acc <= beat_ext;
        end else if (add) begin
            acc <= acc + beat_ext;
        end
    end

    assign out_ovf = |acc[ACC_W-1:DATA_W];

`ifdef ACC32_STAGE_SAT_EN
    assign out_sum = out_ovf ? {DATA_W{1'b1}} : acc[DATA_W-1:0];
`else
    assign out_sum = acc[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_acc32_stage.sv
// Directed bench for acc32_stage: a scoreboard queue holds expected results,
// popped by a monitor on each out_valid/out_ready transfer.
module tb_acc32_stage;

    localparam int BEATS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_s;
    logic        in_co;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_ovf;

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } exp_t;

    exp_t        sbQueue[$];
    exp_t        monItem;
    logic [63:0] modelTotal;
    int          checks = 0;
    int          failures = 0;
    int          xferCount = 0;
    int          xferBefore;

    always #5 clk = ~clk;

    acc32_stage #(
        .BEATS(BEATS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_s     (in_s),
        .in_co    (in_co),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive one beat for a single cycle; the model tracks the exact 64-bit total.
    task automatic applyStimulus(input logic [31:0] s, input logic co);
        checkOutput("in_ready_before_beat", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_s     = s;
        in_co    = co;
        modelTotal = modelTotal + {31'd0, co, s};
        step();
        in_valid = 1'b0;
    endtask

    task automatic expectResult();
        exp_t e;
        e.ovf = |modelTotal[63:32];
`ifdef ACC32_STAGE_SAT_EN
        e.sum = e.ovf ? 32'hFFFF_FFFF : modelTotal[31:0];
`else
        e.sum = modelTotal[31:0];
`endif
        sbQueue.push_back(e);
        modelTotal = '0;
    endtask

    // Transfer happens at the next rising edge whenever these hold mid-cycle.
    always @(negedge clk) begin
        if (!rst && !clr && out_valid && out_ready) begin
            xferCount++;
            checks++;
            assert (sbQueue.size() != 0)
            else begin
                failures++;
                $error("[TB] FAIL sb_unexpected_output observed=0x%0h expected=none", out_sum);
            end
            if (sbQueue.size() != 0) begin
                monItem = sbQueue.pop_front();
                checkOutput("sb_sum", 64'(out_sum), 64'(monItem.sum));
                checkOutput("sb_ovf", 64'(out_ovf), 64'(monItem.ovf));
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_s = '0; in_co = 1'b0;
        out_ready = 1'b0; modelTotal = '0;
        #3;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_sum", 64'(out_sum), 64'd0);
        checkOutput("reset_out_ovf", 64'(out_ovf), 64'd0);
        @(posedge clk);
        step();
        rst = 1'b0;

        $display("[TB] basic sum");
        out_ready = 1'b1;
        applyStimulus(32'd1, 1'b0);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'd3, 1'b0);
        checkOutput("basic_not_early", 64'(out_valid), 64'd0);
        applyStimulus(32'd4, 1'b0);
        expectResult();
        checkOutput("basic_valid_latency", 64'(out_valid), 64'd1);
        checkOutput("basic_in_ready_hold", 64'(in_ready), 64'd0);
        checkOutput("basic_sum", 64'(out_sum), 64'h0000_000A);
        checkOutput("basic_ovf", 64'(out_ovf), 64'd0);
        step();
        checkOutput("basic_released", 64'(out_valid), 64'd0);
        checkOutput("basic_xfer", 64'(xferCount), 64'd1);

        $display("[TB] carry and overflow");
        for (int i = 0; i < BEATS; i++) applyStimulus(32'hFFBF_FFFF, 1'b1);
        expectResult();
        checkOutput("carry_valid", 64'(out_valid), 64'd1);
`ifdef ACC32_STAGE_SAT_EN
        checkOutput("carry_sum", 64'(out_sum), 64'hFFFF_FFFF);
`else
        checkOutput("carry_sum", 64'(out_sum), 64'hFEFF_FFFC);
`endif
        checkOutput("carry_ovf", 64'(out_ovf), 64'd1);
        step();
        checkOutput("carry_xfer", 64'(xferCount), 64'd2);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        for (int i = 0; i < BEATS; i++) applyStimulus(32'd7, 1'b0);
        expectResult();
        in_valid = 1'b1; in_s = 32'd99; in_co = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid_held", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
            checkOutput("bp_sum_stable", 64'(out_sum), 64'd28);
            step();
        end
        checkOutput("bp_no_xfer_yet", 64'(xferCount), 64'd2);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        checkOutput("bp_released", 64'(out_valid), 64'd0);
        checkOutput("bp_in_ready_back", 64'(in_ready), 64'd1);
        checkOutput("bp_one_xfer", 64'(xferCount), 64'd3);
        step();
        checkOutput("bp_still_one_xfer", 64'(xferCount), 64'd3);

        $display("[TB] bubbles");
        for (int i = 0; i < BEATS; i++) begin
            in_valid = 1'b0;
            step();
            applyStimulus(32'd5, 1'b0);
        end
        expectResult();
        checkOutput("bubble_valid", 64'(out_valid), 64'd1);
        checkOutput("bubble_sum", 64'(out_sum), 64'd20);
        step();

        $display("[TB] clear mid-accumulation");
        applyStimulus(32'd9, 1'b0);
        applyStimulus(32'd9, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_s = 32'd50;
        step();
        clr = 1'b0; in_valid = 1'b0; modelTotal = '0;
        checkOutput("clr_valid", 64'(out_valid), 64'd0);
        checkOutput("clr_in_ready", 64'(in_ready), 64'd1);
        checkOutput("clr_acc_zero", 64'(out_sum), 64'd0);
        for (int i = 0; i < BEATS; i++) applyStimulus(32'd1, 1'b0);
        expectResult();
        checkOutput("clr_then_sum", 64'(out_sum), 64'd4);
        step();

        $display("[TB] clear during hold");
        out_ready = 1'b0;
        for (int i = 0; i < BEATS; i++) applyStimulus(32'd2, 1'b0);
        modelTotal = '0;
        checkOutput("clrhold_valid", 64'(out_valid), 64'd1);
        xferBefore = xferCount;
        clr = 1'b1; out_ready = 1'b1;
        step();
        clr = 1'b0;
        checkOutput("clrhold_dropped", 64'(out_valid), 64'd0);
        checkOutput("clrhold_acc_zero", 64'(out_sum), 64'd0);
        checkOutput("clrhold_no_xfer", 64'(xferCount), 64'(xferBefore));

        $display("[TB] reset during hold");
        out_ready = 1'b0;
        for (int i = 0; i < BEATS; i++) applyStimulus(32'd3, 1'b0);
        modelTotal = '0;
        checkOutput("rsthold_valid", 64'(out_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_async_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_async_sum", 64'(out_sum), 64'd0);
        checkOutput("rst_async_ovf", 64'(out_ovf), 64'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < BEATS; i++) applyStimulus(32'h10, 1'b0);
        expectResult();
        checkOutput("post_rst_sum", 64'(out_sum), 64'h40);
        step();
        step();

        checkOutput("sb_drained", 64'(sbQueue.size()), 64'd0);
        checkOutput("total_xfers", 64'(xferCount), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
